dma_wr: RTL
===========

// Module: dma_wr
// PURPOSE
//  Write-back DMA: accepts fp16 result elements streamed from conv/pool cores and packs them into memory words.
//  Writes the words to external memory over the MIG-style command/write-data port, in bursts.
//  Companion to dma (the read engine). It is programmed by csb through a start/base/len triple.
// PARAMETERS
//  DATA_W      16  result element width (fp16)
//  MEM_W       32  memory word width; PACK = MEM_W/DATA_W elements per word (integer, >=1)
//  ADDR_W      30  memory byte-address width
//  BURST_LEN   16  max memory words per burst (1..64)
//  FIFO_DEPTH  64  internal word FIFO depth (power of 2, >= BURST_LEN)
// PORTS
//  clk            in   1          clock
//  rst            in   1          synchronous active-high reset
//  start          in   1          1-cycle pulse from csb; latches base_addr/len; ignored while busy
//  base_addr      in   ADDR_W     destination byte address, aligned to MEM_W/8
//  len            in   24         element count
//  busy           out  1          job in progress
//  done           out  1          1-cycle pulse at job end
//  s_data         in   DATA_W     result element
//  s_valid        in   1          element valid
//  s_ready        out  1          element accepted when s_valid&&s_ready
//  mem_cmd_en     out  1          command strobe (1 cycle per burst)
//  mem_cmd_instr  out  3          always 3'b000 (write)
//  mem_cmd_bl     out  6          burst words - 1
//  mem_cmd_addr   out  ADDR_W     burst start byte address
//  mem_cmd_full   in   1          command port full
//  mem_wr_en      out  1          write-data strobe
//  mem_wr_data    out  MEM_W      packed word
//  mem_wr_mask    out  MEM_W/8    1 = byte NOT written
//  mem_wr_full    in   1          write-data FIFO full
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; FIFO, pack register and counters cleared. rst mid-job aborts it the same way, with no done pulse.
//  States: IDLE -> RUN -> WDATA -> CMD -> (RUN | FIN) -> IDLE.
//  IDLE: start&&len!=0 -> latch, busy=1 next cycle, RUN. start&&len==0 -> done pulse next cycle, stay IDLE.
//  s_ready = busy && FIFO !full && elems_left!=0. No elements are accepted beyond len; s_ready is low in IDLE.
//  Packing: first element of a word in bits [DATA_W-1:0], ascending.
//    A word is pushed when PACK lanes are filled or the last element arrives.
//    In a partial word, empty lanes are 0 and their mask bytes are 1.
//  Total words W = ceil(len/PACK).
//  RUN -> WDATA when fifo_count>=BURST_LEN, or when all elements are packed and fifo_count>0.
//  WDATA: n = min(BURST_LEN, fifo_count) is latched on entry.
//    Pops one word per cycle onto mem_wr_* while !mem_wr_full; mem_wr_en never asserts while mem_wr_full is high.
//  CMD (after the n-th word; data precedes command): mem_cmd_en for exactly 1 cycle with !mem_cmd_full.
//    Outputs mem_cmd_addr = cur_addr, mem_cmd_bl = n-1. Then cur_addr += n*MEM_W/8, wrapping mod 2^ADDR_W.
//  After CMD: if words_issued==W -> FIN, else RUN. FIN: done=1 for 1 cycle, busy=0, IDLE.
//  Input may continue filling the FIFO during WDATA/CMD. Push and pop in the same cycle leave the count unchanged.
//  Latency: the first element is accepted the cycle after start at earliest.
//    The first mem_wr_en comes 1 cycle after the burst condition is met.
// CONFIGURATION
//  DMA_WR_PERF_CNT_EN defined: adds output perf_cycles[31:0].
//    Cleared on accepted start; counts every busy cycle, saturating at 2^32-1; holds after done until the next start.
//  Undefined: no port, no counter logic.
// STRUCTURE
//  Package dma_pkg holds the state encoding, CMD_WR=3'b000, and a clog2 function. The same package is used by dma.
//  One sub-module: dma_wr_fifo, a synchronous FIFO of MEM_W data + MEM_W/8 mask, FIFO_DEPTH deep, with a count output.
// TESTING
//  1. len=32, base=0x100, continuous s_valid -> 16 wr_en (words {e1,e0}..), then one cmd_en addr=0x100 bl=15; done once.
//  2. len=5 -> 3 words; last word data={16'h0,e4}, mask=4'b1100; cmd bl=2.
//  3. len=40, base=0 -> bursts of 16 then 4 words; cmd addr 0x00 bl=15, then addr 0x40 bl=3.
//  4. mem_wr_full toggling every cycle, mem_cmd_full high 10 cycles, len=32 -> no wr_en/cmd_en while full; data intact; done.
//  5. start with len=0 -> done 1 cycle later; no mem_* activity; s_ready stays 0.
//  6. rst after 7 wr_en of a burst -> next cycle all outputs 0, busy=0, no done; then start len=4 -> clean 2-word burst at new base.

Source files
------------

// File: rtl/dma_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dma_pkg                                                |
// | Description : Shared definitions for the DMA read/write engines:     |
// |               FSM state encoding, memory command codes and a clog2   |
// |               helper for sizing counters and pointers.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package dma_pkg;

    // FSM state encoding
    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_RUN   = 3'd1;
    localparam logic [2:0] c_WDATA = 3'd2;
    localparam logic [2:0] c_CMD   = 3'd3;
    localparam logic [2:0] c_FIN   = 3'd4;

    // Memory port command code for a write
    localparam logic [2:0] CMD_WR = 3'b000;

    // Smallest r such that 2**r >= value
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_wr_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dma_wr_if                                              |
// | Description : Element stream input plus MIG-style command/write-data |
// |               port of the write-back DMA. master = DMA side,         |
// |               slave = producer/memory side.                          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface dma_wr_if #(
    parameter int DATA_W = 16,
    parameter int MEM_W  = 32,
    parameter int ADDR_W = 30
) ();
    logic [DATA_W-1:0]  s_data;
    logic               s_valid;
    logic               s_ready;
    logic               mem_cmd_en;
    logic [2:0]         mem_cmd_instr;
    logic [5:0]         mem_cmd_bl;
    logic [ADDR_W-1:0]  mem_cmd_addr;
    logic               mem_cmd_full;
    logic               mem_wr_en;
    logic [MEM_W-1:0]   mem_wr_data;
    logic [MEM_W/8-1:0] mem_wr_mask;
    logic               mem_wr_full;

    modport master (
        input  s_data, s_valid, mem_cmd_full, mem_wr_full,
        output s_ready, mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_addr,
               mem_wr_en, mem_wr_data, mem_wr_mask
    );

    modport slave (
        output s_data, s_valid, mem_cmd_full, mem_wr_full,
        input  s_ready, mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_addr,
               mem_wr_en, mem_wr_data, mem_wr_mask
    );
endinterface
`default_nettype wire

// File: rtl/dma_wr_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dma_wr_fifo                                            |
// | Description : Synchronous show-ahead FIFO holding packed words with  |
// |               their byte masks; exposes an occupancy count.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module dma_wr_fifo
    import dma_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int DEPTH = 64,
    localparam int c_PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1,
    localparam int c_CNT_W = clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [WIDTH-1:0]   din,
    input  logic               pop,
    output logic [WIDTH-1:0]   dout,
    output logic               full,
    output logic [c_CNT_W-1:0] count
);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign full      = (r_count == c_CNT_W'(DEPTH));
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && (r_count != '0);
    assign dout      = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Storage write; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma_wr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dma_wr                                                 |
// | Description : Write-back DMA. Packs fp16 result elements into memory |
// |               words, buffers them and writes them out in bursts      |
// |               (data first, then command) over a MIG-style port.      |
// |               Optional macro DMA_WR_PERF_CNT_EN adds perf_cycles,    |
// |               a saturating count of busy cycles per job.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module dma_wr
    import dma_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int MEM_W      = 32,
    parameter int ADDR_W     = 30,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [23:0]       len,
    output logic              busy,
    output logic              done,
`ifdef DMA_WR_PERF_CNT_EN
    output logic [31:0]       perf_cycles,
`endif
    dma_wr_if.master          bus
);

    localparam int c_PACK       = MEM_W / DATA_W;
    localparam int c_BYTES      = MEM_W / 8;
    localparam int c_LANE_BYTES = DATA_W / 8;
    localparam int c_LANE_W     = (c_PACK > 1) ? clog2(c_PACK) : 1;
    localparam int c_CNT_W      = clog2(FIFO_DEPTH) + 1;
    localparam int c_FW         = MEM_W + c_BYTES;

    logic [2:0]          r_state;
    logic [2:0]          w_next_state;
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [23:0]         r_elems_left;
    logic [23:0]         r_words_total;
    logic [23:0]         r_words_issued;
    logic [MEM_W-1:0]    r_pack_data;
    logic [c_LANE_W-1:0] r_lane;
    logic [6:0]          r_burst_n;
    logic [6:0]          r_burst_cnt;
    logic                r_zero_done;

    logic [c_CNT_W-1:0]  w_fifo_count;
    logic                w_fifo_full;
    logic [c_FW-1:0]     w_fifo_dout;
    logic                w_s_ready;
    logic                w_accept;
    logic                w_word_done;
    logic                w_push;
    logic                w_pop;
    logic                w_cmd_en;
    logic                w_burst_go;
    logic [6:0]          w_burst_n;
    logic                w_start_job;
    logic [24:0]         w_words_calc;
    logic [MEM_W-1:0]    w_pack_next;
    logic [c_BYTES-1:0]  w_mask;

    assign w_start_job  = (r_state == c_IDLE) && start && (len != 24'd0);
    assign w_words_calc = ({1'b0, len} + 25'(c_PACK - 1)) / 25'(c_PACK);
    assign w_s_ready    = busy && !w_fifo_full && (r_elems_left != 24'd0);
    assign w_accept     = bus.s_valid && w_s_ready;
    assign w_word_done  = (r_lane == c_LANE_W'(c_PACK - 1)) || (r_elems_left == 24'd1);
    assign w_push       = w_accept && w_word_done;
    assign w_burst_go   = (w_fifo_count >= c_CNT_W'(BURST_LEN)) ||
                          ((r_elems_left == 24'd0) && (w_fifo_count != '0));
    assign w_burst_n    = (w_fifo_count >= c_CNT_W'(BURST_LEN)) ? 7'(BURST_LEN) : 7'(w_fifo_count);

    // Insert the incoming element into its lane and mask off the lanes still empty
    always_comb begin
        w_pack_next = r_pack_data;
        w_mask      = '0;
        for (int l = 0; l < c_PACK; l++) begin
            if (r_lane == c_LANE_W'(l)) begin
                w_pack_next[l*DATA_W +: DATA_W] = bus.s_data;
            end
            if (c_LANE_W'(l) > r_lane) begin
                w_mask[l*c_LANE_BYTES +: c_LANE_BYTES] = {c_LANE_BYTES{1'b1}};
            end
        end
    end

    dma_wr_fifo #(
        .WIDTH (c_FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   ({w_mask, w_pack_next}),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .count (w_fifo_count)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_start_job) w_next_state = c_RUN;
            c_RUN:   if (w_burst_go) w_next_state = c_WDATA;
            c_WDATA: if (w_pop && (r_burst_cnt == r_burst_n - 7'd1)) w_next_state = c_CMD;
            c_CMD: begin
                if (!bus.mem_cmd_full) begin
                    w_next_state = (r_words_issued + 24'(r_burst_n) == r_words_total) ? c_FIN : c_RUN;
                end
            end
            c_FIN:   w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // FSM outputs: status flags and memory-port strobes
    always_comb begin
        busy     = (r_state == c_RUN) || (r_state == c_WDATA) || (r_state == c_CMD);
        done     = (r_state == c_FIN) || r_zero_done;
        w_pop    = (r_state == c_WDATA) && !bus.mem_wr_full && (r_burst_cnt != r_burst_n);
        w_cmd_en = (r_state == c_CMD) && !bus.mem_cmd_full;
    end

    // Job registers: latch on start, pack elements, track bursts and address
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_addr     <= '0;
            r_elems_left   <= '0;
            r_words_total  <= '0;
            r_words_issued <= '0;
            r_pack_data    <= '0;
            r_lane         <= '0;
            r_burst_n      <= '0;
            r_burst_cnt    <= '0;
            r_zero_done    <= 1'b0;
        end else begin
            r_zero_done <= (r_state == c_IDLE) && start && (len == 24'd0);
            if (w_start_job) begin
                r_cur_addr     <= base_addr;
                r_elems_left   <= len;
                r_words_total  <= w_words_calc[23:0];
                r_words_issued <= '0;
                r_pack_data    <= '0;
                r_lane         <= '0;
            end else begin
                if (w_accept) begin
                    r_elems_left <= r_elems_left - 24'd1;
                    if (w_word_done) begin
                        r_pack_data <= '0;
                        r_lane      <= '0;
                    end else begin
                        r_pack_data <= w_pack_next;
                        r_lane      <= r_lane + 1'b1;
                    end
                end
                if ((r_state == c_RUN) && w_burst_go) begin
                    r_burst_n   <= w_burst_n;
                    r_burst_cnt <= '0;
                end else if (w_pop) begin
                    r_burst_cnt <= r_burst_cnt + 7'd1;
                end
                if (w_cmd_en) begin
                    r_cur_addr     <= r_cur_addr + ADDR_W'(r_burst_n) * ADDR_W'(c_BYTES);
                    r_words_issued <= r_words_issued + 24'(r_burst_n);
                end
            end
        end
    end

    assign bus.s_ready       = w_s_ready;
    assign bus.mem_wr_en     = w_pop;
    assign bus.mem_wr_data   = w_pop ? w_fifo_dout[MEM_W-1:0] : '0;
    assign bus.mem_wr_mask   = w_pop ? w_fifo_dout[c_FW-1:MEM_W] : '0;
    assign bus.mem_cmd_en    = w_cmd_en;
    assign bus.mem_cmd_instr = CMD_WR;
    assign bus.mem_cmd_bl    = w_cmd_en ? 6'(r_burst_n - 7'd1) : '0;
    assign bus.mem_cmd_addr  = w_cmd_en ? r_cur_addr : '0;

`ifdef DMA_WR_PERF_CNT_EN
    logic [31:0] r_perf_cycles;

    // Busy-cycle counter: cleared on an accepted start, saturates, holds after done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cycles <= '0;
        end else if ((r_state == c_IDLE) && start) begin
            r_perf_cycles <= '0;
        end else if (busy && (r_perf_cycles != 32'hFFFF_FFFF)) begin
            r_perf_cycles <= r_perf_cycles + 32'd1;
        end
    end

    assign perf_cycles = r_perf_cycles;
`endif

endmodule
`default_nettype wire
